// File: rtl/br_pkg.sv
// ----------------------------------------------------------------------------
// br_pkg
//   Shared definitions for the reg_bank_mp register bank:
//     - default register width
//     - clear-sequencer state encoding
//     - write-port index constants (order also sets the priority: higher wins)
// ----------------------------------------------------------------------------
package br_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_DONE  = 2'd1,
    ST_READY = 2'd2
  } br_state_e;

  // Write ports, lowest priority first.
  localparam int WP_WB  = 0;  // writeback
  localparam int WP_LD  = 1;  // load return
  localparam int NWPORT = 2;

endpackage

// File: rtl/reg_bank_mp_clear_fsm.sv
// ----------------------------------------------------------------------------
// br_clear_fsm
//   Clear sequencer for reg_bank_mp. After reset, or after a clr request
//   accepted while the bank is usable, it sweeps every entry to zero, one
//   entry per cycle, then reports the bank usable again.
//
//   clk, rst   clock / asynchronous active-high reset
//   clr        clear request, honoured only while ready = 1
//   wr_req     any write enable from the data path this cycle
//   ready      1 = bank usable (DONE or READY)
//   wr_ok      data-path writes may commit at the next edge
//   clr_we     sweep write enable (zero into clr_addr)
//   clr_addr   entry being cleared this cycle
//   wr_err     sticky: write attempted while ready = 0; cleared by rst or clr
// ----------------------------------------------------------------------------
module br_clear_fsm
  import br_pkg::*;
#(
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_req,
  output logic          ready,
  output logic          wr_ok,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          wr_err
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  br_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q;

  // DONE is the one-cycle hand-over after the last entry was cleared; the
  // bank is usable from then on, which keeps the not-ready window at exactly
  // NREG cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (ptr_q == LAST) state_d = ST_DONE;
      ST_DONE:  state_d = clr ? ST_CLEAR : ST_READY;
      ST_READY: if (clr) state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign ready    = (state_q == ST_DONE) || (state_q == ST_READY);
  assign wr_ok    = ready && !clr;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = ptr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      wr_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      // NREG is a power of two, so the pointer wraps back to 0 after the
      // last entry and is already 0 when the next sweep begins.
      ptr_q   <= (state_q == ST_CLEAR) ? ptr_q + AW'(1) : '0;
      if (ready && clr)
        wr_err <= 1'b0;
      else if (!ready && wr_req)
        wr_err <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_mp.sv
// ----------------------------------------------------------------------------
// reg_bank_mp
//   NREG x XLEN register bank: NRD combinational read ports, two synchronous
//   write ports (port 0 writeback, port 1 load return; port 1 wins on the
//   same address), and a clear sweep after reset or clr.
//
//   clk, rst   clock / asynchronous active-high reset
//   clr        clear request (sampled while ready = 1)
//   ready      1 = bank usable; 0 during the clear sweep
//   we0/wa0/wd0  write port 0 (writeback)
//   we1/wa1/wd1  write port 1 (load return)
//   ra         read addresses, port k at [k*AW +: AW]
//   rd         read data, port k at [k*XLEN +: XLEN]; all 0 while ready = 0
//   wr_err     sticky write-while-not-ready flag
//
//   Optional feature macro BR_BYPASS_EN: same-cycle write data is forwarded
//   to matching read ports (port 1 priority). Undefined: rd shows pre-edge
//   array contents.
// ----------------------------------------------------------------------------
module reg_bank_mp
  import br_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                ready,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic                wr_err
);

  logic [XLEN-1:0] mem [NREG];

  logic            wr_ok;
  logic            clr_we;
  logic [AW-1:0]   clr_addr;

  logic            wen   [NWPORT];
  logic [AW-1:0]   waddr [NWPORT];
  logic [XLEN-1:0] wdata [NWPORT];

  br_clear_fsm #(.NREG(NREG)) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_req   (we0 || we1),
    .ready    (ready),
    .wr_ok    (wr_ok),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .wr_err   (wr_err)
  );

  // Per-port qualified enables; writes to entry 0 vanish when it is hard-wired.
  always_comb begin
    waddr[WP_WB] = wa0;
    wdata[WP_WB] = wd0;
    waddr[WP_LD] = wa1;
    wdata[WP_LD] = wd1;
    wen[WP_WB]   = we0 && wr_ok && !(ZERO_REG != 0 && wa0 == '0);
    wen[WP_LD]   = we1 && wr_ok && !(ZERO_REG != 0 && wa1 == '0);
  end

  // NOTE: the array has no reset; it is zeroed by the clear sweep instead,
  // which lets it map onto plain storage. Within one edge the later
  // non-blocking assignment wins, so iterating ports in index order gives
  // the load-return port priority on a shared address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int p = 0; p < NWPORT; p++)
        if (wen[p]) mem[waddr[p]] <= wdata[p];
    end
  end

  always_comb begin
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      automatic logic [AW-1:0]   a = ra[k*AW +: AW];
      automatic logic [XLEN-1:0] v = mem[a];
`ifdef BR_BYPASS_EN
      // Forward only writes that will actually commit at the coming edge.
      if (wen[WP_LD] && waddr[WP_LD] == a)
        v = wdata[WP_LD];
      else if (wen[WP_WB] && waddr[WP_WB] == a)
        v = wdata[WP_WB];
`endif
      if (!ready || (ZERO_REG != 0 && a == '0))
        v = '0;
      rd[k*XLEN +: XLEN] = v;
    end
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// ----------------------------------------------------------------------------
// tb_reg_bank_mp
//   Self-checking bench for reg_bank_mp (default parameters). A behavioural
//   model (array of values plus a "cycles of sweep left" counter) is compared
//   against the DUT on every falling edge; directed sequences add literal
//   expectations, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_reg_bank_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                clr;
  logic                ready;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                wr_err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model
  logic [XLEN-1:0] mem_m [NREG];
  int              sweep_left;
  bit              err_m;

  reg_bank_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .ready  (ready),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .ra     (ra),
    .rd     (rd),
    .wr_err (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sweep_left = NREG;
    err_m      = 1'b0;
    foreach (mem_m[i]) mem_m[i] = '0;
  endtask

  // One rising edge of the bank, from the rules: not usable for NREG cycles
  // after reset/clear; writes only when usable; clear wins over writes.
  task automatic model_edge();
    if (sweep_left > 0) begin
      if (we0 || we1) err_m = 1'b1;
      sweep_left--;
    end else if (clr) begin
      sweep_left = NREG;
      err_m      = 1'b0;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else begin
      if (we0 && wa0 != 0) mem_m[wa0] = wd0;
      if (we1 && wa1 != 0) mem_m[wa1] = wd1;
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int k);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = ra[k*AW +: AW];
    if (sweep_left > 0 || a == 0) return '0;
    v = mem_m[a];
`ifdef BR_BYPASS_EN
    if (!clr) begin
      if (we1 && wa1 == a)      v = wd1;
      else if (we0 && wa0 == a) v = wd0;
    end
`endif
    return v;
  endfunction

  // Compare process: inputs change just after rising edges, so the falling
  // edge sees settled inputs and outputs.
  always @(negedge clk) begin
    check("ready", {31'b0, ready}, {31'b0, sweep_left == 0});
    check("wr_err", {31'b0, wr_err}, {31'b0, err_m});
    for (int k = 0; k < NRD; k++)
      check($sformatf("rd%0d", k), rd[k*XLEN +: XLEN], exp_rd(k));
  end

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #2;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    check(name, n, 32);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
    #1;
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_wr_err", {31'b0, wr_err}, 32'd0);
    step(); step();

    // 1. reset sweep length
    rst = 1'b0;
    ra  = {5'd3, 5'd5};
    wait_ready("reset_sweep_len");

    // 2. simple write, then write to x0
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    step(); idle();
    ra = {5'd0, 5'd5}; #1;
    check("x5_read", rd[31:0], 32'hDEADBEEF);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h0000_1234;
    step(); idle();
    ra = {5'd5, 5'd0}; #1;
    check("x0_read", rd[31:0], 32'h0);
    check("x0_no_err", {31'b0, wr_err}, 32'd0);

    // 3. same-address and different-address dual writes
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222;
    step(); idle();
    ra = {5'd7, 5'd7}; #1;
    check("same_addr_p1_wins", rd[31:0], 32'h22222222);
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h22222222;
    step(); idle();
    ra = {5'd8, 5'd7}; #1;
    check("dual_x7", rd[31:0], 32'h11111111);
    check("dual_x8", rd[63:32], 32'h22222222);

    // 4. load x1..x31, clear, write during sweep
    for (int r = 1; r < NREG; r++) begin
      we0 = 1'b1; wa0 = AW'(r); wd0 = 32'h01010101 * r;
      step();
    end
    idle();
    ra = {5'd31, 5'd17}; #1;
    check("x17_loaded", rd[31:0], 32'h11111111);
    clr = 1'b1;
    step(); idle();
    begin
      int n = 0;
      while (!ready && n < 200) begin
        if (n == 5) begin we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0BAD0BAD; end
        step();
        we0 = 1'b0;
        n++;
      end
      check("clr_sweep_len", n, 32);
    end
    check("sweep_write_err", {31'b0, wr_err}, 32'd1);
    for (int r = 0; r < NREG; r++) begin
      ra = {AW'(r), AW'(r)}; #1;
      check($sformatf("cleared_x%0d", r), rd[31:0] | rd[63:32], 32'h0);
    end

    // 5. reset at sweep cycle 10
    clr = 1'b1;
    step(); idle();
    repeat (10) step();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_ready", {31'b0, ready}, 32'd0);
    step(); step();
    rst = 1'b0;
    wait_ready("rst_restart_len");
    check("rst_clears_err", {31'b0, wr_err}, 32'd0);

    // 6. same-cycle write and read
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFEF00D;
    ra = {5'd3, 5'd0}; #1;
`ifdef BR_BYPASS_EN
    check("bypass_rd1", rd[63:32], 32'hCAFEF00D);
`else
    check("bypass_rd1", rd[63:32], 32'h0);
`endif
    step(); idle(); #1;
    check("x3_after", rd[63:32], 32'hCAFEF00D);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = AW'($urandom);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      ra  = ($urandom_range(0, 2) == 0) ? {wa1, wa0} : NRD*AW'($urandom);
      clr = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
